// File: rtl/wm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wm_pkg
//  Description : Shared types and constants for the washing-machine program
//                controller: phase state encoding, program mode codes and
//                the quick-mode duration helper.
//  Revision    : 1.0  initial release
// ============================================================================
package wm_pkg;

    // Phase encoding is visible on the phase output, so values are fixed.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4,
        DONE  = 3'd5
    } wm_state_t;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_QUICK  = 2'd1;
    localparam logic [1:0] MODE_SPIN   = 2'd2;

    // Quick programs halve WASH/RINSE but never drop a phase to zero length.
    function automatic int quick_cycles(input int d);
        return ((d >> 1) >= 1) ? (d >> 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wm_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wm_phase_timer
//  Description : Down-counting phase timer. Loads a start value, counts down
//                once per cycle unless held, and stops at zero.
//  Ports       : clk, reset (sync, active-high)
//                load / load_val : load start value (has priority over hold)
//                hold            : freeze the count for this cycle
//                count           : current count
//                zero            : count == 0
//  Revision    : 1.0  initial release
// ============================================================================
module wm_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (!hold && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/wm_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wm_cycle_ctrl
//  Description : Washing-machine program controller. Runs
//                FILL -> WASH -> N_RINSE x RINSE -> SPIN -> DONE with per-phase
//                cycle timers, pause/resume with a frozen timer, and
//                normal / quick / spin-only programs.
//  Ports       : clk, reset (sync, active-high)
//                start_button, pause_button : debounced level inputs
//                mode [1:0]   : program, sampled only when a program starts
//                out          : done flag (DONE phase)
//                water_valve, motor_on, spin_on : actuators, off while paused
//                door_lock    : held through every active phase incl. pause
//                paused       : active phase is frozen
//                phase [2:0]  : current phase code
//                rinse_left [3:0] : rinse passes remaining incl. current one
//  Revision    : 1.0  initial release
// ============================================================================
module wm_cycle_ctrl
    import wm_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int FILL_CYCLES  = 32,
    parameter int WASH_CYCLES  = 64,
    parameter int RINSE_CYCLES = 32,
    parameter int N_RINSE      = 2,
    parameter int SPIN_CYCLES  = 48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_button,
    input  logic       pause_button,
    input  logic [1:0] mode,
    output logic       out,
    output logic       water_valve,
    output logic       motor_on,
    output logic       spin_on,
    output logic       door_lock,
    output logic       paused,
    output logic [2:0] phase,
    output logic [3:0] rinse_left
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    localparam longint c_cnt_lim = longint'(1) << CNT_W;

    generate
        if (FILL_CYCLES < 1 || longint'(FILL_CYCLES) >= c_cnt_lim ||
            WASH_CYCLES < 1 || longint'(WASH_CYCLES) >= c_cnt_lim ||
            RINSE_CYCLES < 1 || longint'(RINSE_CYCLES) >= c_cnt_lim ||
            SPIN_CYCLES < 1 || longint'(SPIN_CYCLES) >= c_cnt_lim ||
            N_RINSE < 1 || N_RINSE > 15) begin : g_param_check
            $error("wm_cycle_ctrl: phase cycle counts or N_RINSE out of range");
        end
    endgenerate

    // Timer load values are duration-1: a phase of D cycles sees D-1 .. 0.
    localparam logic [CNT_W-1:0] c_fill_ld    = CNT_W'(FILL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_wash_ld    = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_rinse_ld   = CNT_W'(RINSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_spin_ld    = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_wash_q_ld  = CNT_W'(quick_cycles(WASH_CYCLES) - 1);
    localparam logic [CNT_W-1:0] c_rinse_q_ld = CNT_W'(quick_cycles(RINSE_CYCLES) - 1);
    localparam logic [3:0]       c_n_rinse    = 4'(N_RINSE);
    localparam logic [3:0]       c_rinse_one  = 4'd1;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    wm_state_t  r_state;
    logic [1:0] r_mode;
    logic [3:0] r_rinse_left;
    logic       r_paused;
    logic       r_out;
    logic       r_water_valve;
    logic       r_motor_on;
    logic       r_spin_on;
    logic       r_door_lock;

    wm_state_t        w_state_next;
    logic [1:0]       w_mode_next;
    logic [3:0]       w_rinse_next;
    logic             w_paused_next;
    logic             w_active_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_expire;
    logic             w_quick;
    logic             w_zero;
    logic [CNT_W-1:0] w_timer_count;
    logic             w_unused_count;

    // ------------------------------------------------------------------
    // Phase timer: frozen on paused cycles so the remaining count survives
    // ------------------------------------------------------------------
    wm_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .hold     (r_paused),
        .count    (w_timer_count),
        .zero     (w_zero)
    );

    // Only the zero flag steers the sequencer; the raw count is not needed.
    assign w_unused_count = ^w_timer_count;

    assign w_quick  = (r_mode == MODE_QUICK);
    // A paused cycle never ends a phase, even when the timer is already 0.
    assign w_expire = w_zero && !r_paused;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, timer load and rinse bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_mode_next  = r_mode;
        w_rinse_next = r_rinse_left;
        w_load       = 1'b0;
        w_load_val   = '0;

        case (r_state)
            IDLE: begin
                if (start_button) begin
                    w_mode_next = mode;
                    w_load      = 1'b1;
                    if (mode == MODE_SPIN) begin
                        w_state_next = SPIN;
                        w_load_val   = c_spin_ld;
                        w_rinse_next = '0;
                    end else begin
                        w_state_next = FILL;
                        w_load_val   = c_fill_ld;
                        w_rinse_next = c_n_rinse;
                    end
                end
            end
            FILL: begin
                if (w_expire) begin
                    w_state_next = WASH;
                    w_load       = 1'b1;
                    w_load_val   = w_quick ? c_wash_q_ld : c_wash_ld;
                end
            end
            WASH: begin
                if (w_expire) begin
                    w_state_next = RINSE;
                    w_load       = 1'b1;
                    w_load_val   = w_quick ? c_rinse_q_ld : c_rinse_ld;
                end
            end
            RINSE: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    if (r_rinse_left > c_rinse_one) begin
                        w_rinse_next = r_rinse_left - c_rinse_one;
                        w_load_val   = w_quick ? c_rinse_q_ld : c_rinse_ld;
                    end else begin
                        w_state_next = SPIN;
                        w_rinse_next = '0;
                        w_load_val   = c_spin_ld;
                    end
                end
            end
            SPIN: begin
                if (w_expire) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (!start_button) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_active_next = (w_state_next == FILL) || (w_state_next == WASH) ||
                           (w_state_next == RINSE) || (w_state_next == SPIN);
    // Pause is only meaningful in an active phase; IDLE/DONE ignore it.
    assign w_paused_next = pause_button && w_active_next;

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state and pause so they
    // line up with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode        <= MODE_NORMAL;
            r_rinse_left  <= '0;
            r_paused      <= 1'b0;
            r_out         <= 1'b0;
            r_water_valve <= 1'b0;
            r_motor_on    <= 1'b0;
            r_spin_on     <= 1'b0;
            r_door_lock   <= 1'b0;
        end else begin
            r_mode        <= w_mode_next;
            r_rinse_left  <= w_rinse_next;
            r_paused      <= w_paused_next;
            r_out         <= (w_state_next == DONE);
            r_water_valve <= (w_state_next == FILL) && !w_paused_next;
            r_motor_on    <= ((w_state_next == WASH) || (w_state_next == RINSE)) && !w_paused_next;
            r_spin_on     <= (w_state_next == SPIN) && !w_paused_next;
            r_door_lock   <= w_active_next;
        end
    end

    assign out         = r_out;
    assign water_valve = r_water_valve;
    assign motor_on    = r_motor_on;
    assign spin_on     = r_spin_on;
    assign door_lock   = r_door_lock;
    assign paused      = r_paused;
    assign phase       = r_state;
    assign rinse_left  = r_rinse_left;

endmodule
`default_nettype wire

// File: tb/tb_wm_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wm_cycle_ctrl
//  Description : Self-checking bench for wm_cycle_ctrl. A program-schedule
//                reference model predicts every output cycle; a monitor
//                compares DUT outputs against the queued predictions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wm_cycle_ctrl;

    localparam int F  = 4;
    localparam int W  = 8;
    localparam int R  = 3;
    localparam int NR = 2;
    localparam int S  = 5;
    localparam int WQ = ((W / 2) >= 1) ? (W / 2) : 1;
    localparam int RQ = ((R / 2) >= 1) ? (R / 2) : 1;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       start_button = 1'b0;
    logic       pause_button = 1'b0;
    logic [1:0] mode         = 2'd0;
    logic       out, water_valve, motor_on, spin_on, door_lock, paused;
    logic [2:0] phase;
    logic [3:0] rinse_left;

    wm_cycle_ctrl #(
        .CNT_W        (8),
        .FILL_CYCLES  (F),
        .WASH_CYCLES  (W),
        .RINSE_CYCLES (R),
        .N_RINSE      (NR),
        .SPIN_CYCLES  (S)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_button (start_button),
        .pause_button (pause_button),
        .mode         (mode),
        .out          (out),
        .water_valve  (water_valve),
        .motor_on     (motor_on),
        .spin_on      (spin_on),
        .door_lock    (door_lock),
        .paused       (paused),
        .phase        (phase),
        .rinse_left   (rinse_left)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: a schedule of phase segments --------
    typedef struct {
        int ph;
        int dur;
        int rl;
    } seg_t;

    seg_t        sched[$];
    int          m_ph   = 0;
    int          m_left = 0;
    int          m_rl   = 0;
    bit          m_pz   = 1'b0;
    logic [12:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_bad  = 0;

    function automatic void add_seg(input int ph, input int dur, input int rl);
        seg_t sg;
        sg.ph  = ph;
        sg.dur = dur;
        sg.rl  = rl;
        sched.push_back(sg);
    endfunction

    function automatic void build_program(input logic [1:0] m);
        int wd;
        int rd;
        sched.delete();
        wd = (m == 2'd1) ? WQ : W;
        rd = (m == 2'd1) ? RQ : R;
        if (m == 2'd2) begin
            add_seg(4, S, 0);
        end else begin
            add_seg(1, F, NR);
            add_seg(2, wd, NR);
            for (int k = NR; k >= 1; k--) add_seg(3, rd, k);
            add_seg(4, S, 0);
        end
        add_seg(5, 0, 0);
    endfunction

    function automatic void next_seg();
        seg_t sg;
        sg     = sched.pop_front();
        m_ph   = sg.ph;
        m_left = sg.dur;
        m_rl   = sg.rl;
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit p, input logic [1:0] m);
        if (r) begin
            m_ph = 0;
            m_rl = 0;
            m_pz = 1'b0;
            sched.delete();
        end else begin
            if (m_ph == 0) begin
                if (s) begin
                    build_program(m);
                    next_seg();
                end
            end else if (m_ph == 5) begin
                if (!s) m_ph = 0;
            end else if (!m_pz) begin
                m_left = m_left - 1;
                if (m_left == 0) next_seg();
            end
            m_pz = p && (m_ph >= 1) && (m_ph <= 4);
        end
    endfunction

    function automatic logic [12:0] exp_vec();
        logic act;
        act = (m_ph >= 1) && (m_ph <= 4);
        return {3'(m_ph), 4'(m_rl),
                logic'(m_ph == 5),
                logic'(m_ph == 1) && !m_pz,
                logic'((m_ph == 2) || (m_ph == 3)) && !m_pz,
                logic'(m_ph == 4) && !m_pz,
                act, m_pz};
    endfunction

    // ---------------- stimulus ----------------------------------------------
    task automatic tick(input bit r, input bit s, input bit p, input logic [1:0] m);
        @(negedge clk);
        reset        = r;
        start_button = s;
        pause_button = p;
        mode         = m;
        model_step(r, s, p, m);
        exp_q.push_back(exp_vec());
    endtask

    // Starts a program with start held, pauses active cycles p_at..p_at+p_len-1
    // (cycle 1 = first active cycle), and measures cycles until first DONE.
    task automatic run_program(input string name, input logic [1:0] m,
                               input int p_at, input int p_len, input int exp_len);
        int         c;
        int         done_c;
        bit         p;
        logic [1:0] mm;
        c      = 1;
        done_c = -1;
        mm     = m;
        while (done_c < 0 && c < 200) begin
            p  = (c >= p_at) && (c < p_at + p_len);
            mm = (c == 1) ? m : 2'($urandom_range(0, 3));
            tick(1'b0, 1'b1, p, mm);
            if (c > 1 && out === 1'b1) done_c = c - 1;
            c++;
        end
        n_cmp++;
        if (done_c - 1 != exp_len) begin
            n_bad++;
            $display("FAIL run_len_%s actual=%0d required=%0d", name, done_c - 1, exp_len);
        end
        tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), mm);
        tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), mm);
        tick(1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------------------------
    always @(posedge clk) begin
        logic [12:0] e;
        logic [12:0] a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {phase, rinse_left, out, water_valve, motor_on, spin_on, door_lock, paused};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t actual ph=%0d rl=%0d out/vlv/mot/spn/door/pz=%b required ph=%0d rl=%0d out/vlv/mot/spn/door/pz=%b",
                         $time, a[12:10], a[9:6], a[5:0], e[12:10], e[9:6], e[5:0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(1'b1, 1'b0, 1'b0, 2'd0);
        tick(1'b1, 1'b0, 1'b0, 2'd0);
        tick(1'b0, 1'b0, 1'b0, 2'd0);

        run_program("normal",        2'd0, 0, 0, F + W + NR * R + S);
        run_program("wash_pause",    2'd0, F + 3, 6, F + W + NR * R + S + 6);
        run_program("fill_exp_pause", 2'd0, F, 1, F + W + NR * R + S + 1);
        run_program("idle_pause",    2'd0, 1, 1, F + W + NR * R + S + 1);
        run_program("quick",         2'd1, 0, 0, F + WQ + NR * RQ + S);
        run_program("spin_only",     2'd2, 0, 0, S);
        run_program("mode3",         2'd3, 0, 0, F + W + NR * R + S);

        // Reset in the middle of the first RINSE pass, start held throughout.
        tick(1'b0, 1'b1, 1'b0, 2'd0);
        repeat (F + W + 1) tick(1'b0, 1'b1, 1'b0, 2'd0);
        tick(1'b1, 1'b1, 1'b0, 2'd0);
        repeat (3) tick(1'b0, 1'b1, 1'b0, 2'd1);
        tick(1'b1, 1'b0, 1'b0, 2'd0);
        tick(1'b0, 1'b0, 1'b0, 2'd0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            tick(1'($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 4) == 0),
                 2'($urandom_range(0, 3)));
        end

        tick(1'b0, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
